// File: rtl/byte_striping_pkg.sv
// Shared types for the byte striping / unstriping pair: lane count,
// default lane width, the 4-lane group type and the serialiser states.
package byte_striping_pkg;

    localparam int LANES      = 4;
    localparam int DATA_WIDTH = 8;

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] group_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/byte_unstriping_fifo.sv
// Synchronous FIFO of 4-lane groups; pointers wrap modulo DEPTH (power of 2),
// count is one bit wider so a full FIFO is distinguishable from empty.
module byte_unstriping_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == CW'(0));
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/byte_unstriping.sv
// Receive-side unstriper: buffers 4-lane groups and re-serialises them into
// one byte stream, lane 0 first, with no bubble between consecutive groups.
module byte_unstriping
    import byte_striping_pkg::*;
#(
    parameter int DATA_WIDTH = byte_striping_pkg::DATA_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                  clk1Mhz,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] stripedLane0,
    input  logic [DATA_WIDTH-1:0] stripedLane1,
    input  logic [DATA_WIDTH-1:0] stripedLane2,
    input  logic [DATA_WIDTH-1:0] stripedLane3,
    input  logic                  stripedVLD,
    output logic                  stripedRDY,
    output logic [DATA_WIDTH-1:0] byteUnstripingOUT,
    output logic                  byteUnstripingVLD,
    input  logic                  byteUnstripingRDY
);

    localparam int GW = LANES * DATA_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(LANES);

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] lgroup_t;

    ser_state_t          r_state;
    ser_state_t          w_next_state;
    logic [SW-1:0]       r_sel;
    logic [SW-1:0]       w_next_sel;
    logic [SW-1:0]       w_sel_inc;
    lgroup_t             r_hold;
    lgroup_t             w_next_hold;
    lgroup_t             w_head;
    lgroup_t             w_wr_group;
    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] w_next_out;
    logic                r_vld;
    logic                w_next_vld;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic [GW-1:0]       w_rd_data;

    // Lane 0 lands in element [0] so the serialiser can index by sel directly.
    assign w_wr_group = {stripedLane3, stripedLane2, stripedLane1, stripedLane0};
    assign w_head     = lgroup_t'(w_rd_data);

    // Ready depends only on reset and the registered occupancy.
    assign stripedRDY = reset && (w_count < CW'(DEPTH));
    assign w_push     = stripedVLD && stripedRDY && !w_full;
    assign w_sel_inc  = r_sel + SW'(1);

    byte_unstriping_fifo #(
        .WIDTH (GW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk1Mhz),
        .rst_n     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data (w_wr_group),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // Serialiser next-state: load/pop a group, step sel, or return to idle
    always_comb begin
        w_next_state = r_state;
        w_next_sel   = r_sel;
        w_next_hold  = r_hold;
        w_next_out   = r_out;
        w_next_vld   = r_vld;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_hold  = w_head;
                    w_next_out   = w_head[0];
                    w_next_vld   = 1'b1;
                    w_next_sel   = '0;
                    w_next_state = SEND;
                end else begin
                    w_next_vld   = 1'b0;
                end
            end
            SEND: begin
                if (!byteUnstripingRDY) begin
                    w_next_vld = 1'b1;
                end else if (r_sel != SW'(LANES - 1)) begin
                    w_next_sel = w_sel_inc;
                    w_next_out = r_hold[w_sel_inc];
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_next_hold = w_head;
                    w_next_out  = w_head[0];
                    w_next_sel  = '0;
                end else begin
                    w_next_vld   = 1'b0;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_vld   = 1'b0;
                w_next_sel   = '0;
                w_next_state = IDLE;
            end
        endcase
    end

    // Serialiser state, holding register and flopped byte outputs
    always_ff @(posedge clk1Mhz or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_hold  <= '0;
            r_out   <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_sel   <= w_next_sel;
            r_hold  <= w_next_hold;
            r_out   <= w_next_out;
            r_vld   <= w_next_vld;
        end
    end

    assign byteUnstripingOUT = r_out;
    assign byteUnstripingVLD = r_vld;

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: reset, single/back-to-back groups,
// backpressure, reset mid-group and a randomised wrap-around stream.
module tb_byte_unstriping;

    logic       clk1Mhz;
    logic       reset;
    logic [7:0] stripedLane0;
    logic [7:0] stripedLane1;
    logic [7:0] stripedLane2;
    logic [7:0] stripedLane3;
    logic       stripedVLD;
    logic       stripedRDY;
    logic [7:0] byteUnstripingOUT;
    logic       byteUnstripingVLD;
    logic       byteUnstripingRDY;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    byte_unstriping #(
        .DATA_WIDTH (8),
        .DEPTH      (2)
    ) dut (
        .clk1Mhz           (clk1Mhz),
        .reset             (reset),
        .stripedLane0      (stripedLane0),
        .stripedLane1      (stripedLane1),
        .stripedLane2      (stripedLane2),
        .stripedLane3      (stripedLane3),
        .stripedVLD        (stripedVLD),
        .stripedRDY        (stripedRDY),
        .byteUnstripingOUT (byteUnstripingOUT),
        .byteUnstripingVLD (byteUnstripingVLD),
        .byteUnstripingRDY (byteUnstripingRDY)
    );

    initial clk1Mhz = 1'b0;
    always #5 clk1Mhz = ~clk1Mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1Mhz);
        @(negedge clk1Mhz);
    endtask

    task automatic drive(input logic [7:0] l0, input logic [7:0] l1,
                         input logic [7:0] l2, input logic [7:0] l3);
        stripedLane0 = l0;
        stripedLane1 = l1;
        stripedLane2 = l2;
        stripedLane3 = l3;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  ab [8];
        logic [7:0]  bp [12];
        logic [7:0]  sg [4];
        logic [31:0] grp [10];
        logic [31:0] tmp;
        logic [7:0]  eb;
        logic        acc;
        int          gi;
        int          bi;
        int          cyc;

        // Reset held with random inputs
        reset = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 8'h00);
        stripedVLD        = 1'b0;
        byteUnstripingRDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1Mhz);
            drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            stripedVLD        = 1'($urandom);
            byteUnstripingRDY = 1'($urandom);
            chk("rst_vld", 32'(byteUnstripingVLD), 32'd0);
            chk("rst_out", 32'(byteUnstripingOUT), 32'd0);
            chk("rst_rdy", 32'(stripedRDY), 32'd0);
        end
        drive(8'h00, 8'h00, 8'h00, 8'h00);
        stripedVLD        = 1'b0;
        byteUnstripingRDY = 1'b1;
        reset = 1'b1;
        #1;
        chk("rdy_after_reset", 32'(stripedRDY), 32'd1);
        @(negedge clk1Mhz);

        // Single group, latency and order
        sg = '{8'h00, 8'h0F, 8'hF0, 8'hFF};
        drive(sg[0], sg[1], sg[2], sg[3]);
        stripedVLD = 1'b1;
        tick();
        stripedVLD = 1'b0;
        chk("single_lat0", 32'(byteUnstripingVLD), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("single_vld", 32'(byteUnstripingVLD), 32'd1);
            chk("single_out", 32'(byteUnstripingOUT), 32'(sg[i]));
        end
        tick();
        chk("single_end", 32'(byteUnstripingVLD), 32'd0);

        // Back-to-back groups four cycles apart
        ab = '{8'h00, 8'h0F, 8'hF0, 8'hFF, 8'hFF, 8'hF0, 8'h0F, 8'h00};
        drive(ab[0], ab[1], ab[2], ab[3]);
        stripedVLD = 1'b1;
        tick();
        stripedVLD = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("b2b_rdy", 32'(stripedRDY), 32'd1);
            if (k <= 8) begin
                chk("b2b_vld", 32'(byteUnstripingVLD), 32'd1);
                chk("b2b_out", 32'(byteUnstripingOUT), 32'(ab[k-1]));
            end else begin
                chk("b2b_end", 32'(byteUnstripingVLD), 32'd0);
            end
            if (k == 3) begin
                drive(ab[4], ab[5], ab[6], ab[7]);
                stripedVLD = 1'b1;
            end
            if (k == 4) begin
                stripedVLD = 1'b0;
            end
        end

        // Backpressure: three groups with the consumer stalled
        bp = '{8'h00, 8'h0F, 8'hF0, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78,
               8'h9A, 8'hBC, 8'hDE, 8'hF1};
        byteUnstripingRDY = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("bp_accept", 32'(stripedRDY), 32'd1);
            drive(bp[4*g], bp[4*g+1], bp[4*g+2], bp[4*g+3]);
            stripedVLD = 1'b1;
            tick();
        end
        stripedVLD = 1'b0;
        chk("bp_full", 32'(stripedRDY), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_vld", 32'(byteUnstripingVLD), 32'd1);
            chk("bp_hold_out", 32'(byteUnstripingOUT), 32'h00);
            tick();
        end
        chk("bp_still_full", 32'(stripedRDY), 32'd0);
        byteUnstripingRDY = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("bp_vld", 32'(byteUnstripingVLD), 32'd1);
            chk("bp_out", 32'(byteUnstripingOUT), 32'(bp[i]));
            tick();
        end
        chk("bp_end", 32'(byteUnstripingVLD), 32'd0);

        // Reset asserted after byte 1 of a group
        drive(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        stripedVLD = 1'b1;
        tick();
        stripedVLD = 1'b0;
        tick();
        chk("mid_b0", 32'(byteUnstripingOUT), 32'hAA);
        tick();
        chk("mid_b1", 32'(byteUnstripingOUT), 32'hBB);
        reset = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(byteUnstripingVLD), 32'd0);
        chk("mid_rst_out", 32'(byteUnstripingOUT), 32'd0);
        chk("mid_rst_rdy", 32'(stripedRDY), 32'd0);
        @(negedge clk1Mhz);
        reset = 1'b1;
        #1;
        chk("mid_rel_rdy", 32'(stripedRDY), 32'd1);
        @(negedge clk1Mhz);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_empty", 32'(byteUnstripingVLD), 32'd0);
        end
        sg = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive(sg[0], sg[1], sg[2], sg[3]);
        stripedVLD = 1'b1;
        tick();
        stripedVLD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_new_vld", 32'(byteUnstripingVLD), 32'd1);
            chk("mid_new_out", 32'(byteUnstripingOUT), 32'(sg[i]));
        end
        tick();
        chk("mid_new_end", 32'(byteUnstripingVLD), 32'd0);

        // Wrap-around: 10 random groups, random consumer stalls
        for (int g = 0; g < 10; g++) begin
            grp[g] = $urandom;
        end
        gi  = 0;
        bi  = 0;
        cyc = 0;
        while ((bi < 40) && (cyc < 2000)) begin
            if (gi < 10) begin
                tmp = grp[gi];
                drive(tmp[7:0], tmp[15:8], tmp[23:16], tmp[31:24]);
                stripedVLD = 1'b1;
            end else begin
                stripedVLD = 1'b0;
            end
            acc = stripedVLD && stripedRDY;
            byteUnstripingRDY = ($urandom_range(0, 3) != 0);
            if (byteUnstripingVLD && byteUnstripingRDY) begin
                tmp = grp[bi / 4];
                eb  = tmp[(bi % 4) * 8 +: 8];
                chk("wrap_byte", 32'(byteUnstripingOUT), 32'(eb));
                bi++;
            end
            tick();
            if (acc) begin
                gi++;
            end
            cyc++;
        end
        stripedVLD        = 1'b0;
        byteUnstripingRDY = 1'b1;
        chk("wrap_bytes", 32'(bi), 32'd40);
        chk("wrap_groups", 32'(gi), 32'd10);
        tick();
        chk("wrap_end", 32'(byteUnstripingVLD), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
